// File: rtl/tmec_correct_buffer.sv
// Message-bit buffer for the BCH decoder: holds K-bit messages during decode and emits them
// XOR-corrected by the Chien error flag. Define TMEC_CORRECT_ERRCNT_EN for per-codeword error count.
module tmec_correct_buffer #(
    parameter int unsigned N     = 15,
    parameter int unsigned K     = 5,
    parameter int unsigned T     = 3,
    parameter int unsigned DEPTH = 2 * K
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic din,
    input  logic din_en,
    input  logic err,
    input  logic err_en,
    output logic dout,
    output logic dout_valid,
    output logic dout_last,
    output logic full,
    output logic empty,
    output logic overflow,
    output logic underflow
`ifdef TMEC_CORRECT_ERRCNT_EN
    ,
    output logic [$clog2(T+2)-1:0] err_count,
    output logic                   err_count_valid
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam int unsigned BW = (K > 1) ? $clog2(K) : 1;

    // A t-error BCH code needs at least T parity bits, and the buffer must hold a whole message.
    if (DEPTH < K || K > N || (N - K) < T) begin : g_bad_params
        $error("tmec_correct_buffer: illegal parameters (need DEPTH >= K, K <= N, N-K >= T)");
    end

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [BW-1:0]    obit_q, obit_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_last_q, dout_last_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr, rd, obit_end;

    assign full     = (occ_q == OW'(DEPTH));
    assign empty    = (occ_q == '0);
    assign rd       = err_en && !empty;
    assign wr       = din_en && (!full || rd);
    assign obit_end = (obit_q == BW'(K - 1));

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        obit_d       = obit_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        if (ce) begin
            if (wr) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd) begin
                rd_ptr_d     = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
                dout_d       = mem_q[rd_ptr_q] ^ err;
                dout_valid_d = 1'b1;
                dout_last_d  = obit_end;
                obit_d       = obit_end ? '0 : obit_q + 1'b1;
            end
            case ({wr, rd})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
            if (din_en && !wr) begin
                overflow_d = 1'b1;
            end
            // No bypass: a read on an empty buffer is rejected even if a write lands alongside.
            if (err_en && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            obit_q       <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            obit_q       <= obit_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ce && wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

`ifdef TMEC_CORRECT_ERRCNT_EN
    localparam int unsigned CW = $clog2(T + 2);

    logic [CW-1:0] cnt_q, cnt_d, cnt_base;

    // The first bit of each codeword starts a fresh count.
    assign cnt_base = (obit_q == '0) ? '0 : cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (ce && rd) begin
            cnt_d = (err && cnt_base < CW'(T + 1)) ? cnt_base + 1'b1 : cnt_base;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count       = cnt_q;
    assign err_count_valid = dout_last_q;
`endif

endmodule

// File: tb/tb_tmec_correct_buffer.sv
// Directed self-checking bench for tmec_correct_buffer (K=5, DEPTH=10).
module tb_tmec_correct_buffer;

    logic clk = 1'b0;
    logic reset, ce, din, din_en, err, err_en;
    logic dout, dout_valid, dout_last, full, empty, overflow, underflow;
`ifdef TMEC_CORRECT_ERRCNT_EN
    logic [2:0] err_count;
    logic       err_count_valid;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tmec_correct_buffer #(
        .N    (15),
        .K    (5),
        .T    (3),
        .DEPTH(10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .din       (din),
        .din_en    (din_en),
        .err       (err),
        .err_en    (err_en),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_last (dout_last),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef TMEC_CORRECT_ERRCNT_EN
        ,
        .err_count      (err_count),
        .err_count_valid(err_count_valid)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic c, input logic d, input logic de, input logic e,
                        input logic ee);
        ce = c; din = d; din_en = de; err = e; err_en = ee;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    logic [0:4] w1  = 5'b10110;
    logic [0:4] e1  = 5'b00100;
    logic [0:4] x1  = 5'b10010;
    logic [0:4] w2  = 5'b01101;
    logic [0:4] e2  = 5'b10001;
    logic [0:4] x2  = 5'b11100;
    logic [0:9] fb  = 10'b1100101101;
    logic [0:4] w3  = 5'b01001;
    logic [0:4] ea  = 5'b11111;
    logic [0:4] eb  = 5'b01000;

    initial begin
        reset = 1'b0; ce = 1'b0; din = 1'b0; din_en = 1'b0; err = 1'b0; err_en = 1'b0;
        do_reset();
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_dout", dout, 1'b0);
        check("rst_valid", dout_valid, 1'b0);
        check("rst_last", dout_last, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_unf", underflow, 1'b0);

        // Basic codeword: write 10110, read with err 00100.
        for (int i = 0; i < 5; i++) step(1'b1, w1[i], 1'b1, 1'b0, 1'b0);
        check("basic_nonempty", empty, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, e1[i], 1'b1);
            check($sformatf("basic_dout%0d", i), dout, x1[i]);
            check($sformatf("basic_valid%0d", i), dout_valid, 1'b1);
            check($sformatf("basic_last%0d", i), dout_last, i == 4);
        end
        check("basic_empty", empty, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("basic_valid_drop", dout_valid, 1'b0);

        // ce toggling: ce=0 cycles carry junk strobes that must be ignored.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, w2[i], 1'b1, 1'b0, 1'b0);
            step(1'b0, ~w2[i], 1'b1, 1'b1, 1'b1);
        end
        check("ce_nonfull", full, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, e2[i], 1'b1);
            check($sformatf("ce_dout%0d", i), dout, x2[i]);
            check($sformatf("ce_valid%0d", i), dout_valid, 1'b1);
            check($sformatf("ce_last%0d", i), dout_last, i == 4);
            step(1'b0, 1'b0, 1'b0, ~e2[i], 1'b1);
            check($sformatf("ce_hold_valid%0d", i), dout_valid, 1'b0);
            check($sformatf("ce_hold_dout%0d", i), dout, x2[i]);
        end
        check("ce_empty", empty, 1'b1);
        check("ce_no_unf", underflow, 1'b0);

        // Fill to DEPTH, overflow, then simultaneous read/write while full.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, fb[i], 1'b1, 1'b0, 1'b0);
            if (i == 8) check("fill_not_full9", full, 1'b0);
        end
        check("fill_full", full, 1'b1);
        check("fill_no_ovf", overflow, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ovf_set", overflow, 1'b1);
        check("ovf_full", full, 1'b1);
        check("ovf_no_valid", dout_valid, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("rw_full_dout", dout, fb[0]);
        check("rw_full_valid", dout_valid, 1'b1);
        check("rw_full_full", full, 1'b1);
        check("rw_full_ovf", overflow, 1'b1);
        // Remaining contents: fb[1..9] then the bit written alongside the read (1).
        for (int i = 1; i < 11; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            check($sformatf("drain_dout%0d", i), dout, (i < 10) ? fb[i] : 1'b1);
            check($sformatf("drain_last%0d", i), dout_last, (i == 4) || (i == 9));
        end
        check("drain_empty", empty, 1'b1);

        // Underflow from empty, then simultaneous read/write while empty.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("unf_set", underflow, 1'b1);
        check("unf_no_valid", dout_valid, 1'b0);
        check("unf_dout_hold", dout, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("unf_rw_valid", dout_valid, 1'b0);
        check("unf_rw_nonempty", empty, 1'b0);
        check("unf_rw_flag", underflow, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("unf_rw_readback", dout, 1'b1);
        check("unf_rw_empty", empty, 1'b1);

        // Reset mid-codeword, then a clean codeword.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        check("mid_rst_empty", empty, 1'b1);
        check("mid_rst_ovf", overflow, 1'b0);
        check("mid_rst_unf", underflow, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, w3[i], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            check($sformatf("post_rst_dout%0d", i), dout, w3[i]);
            check($sformatf("post_rst_last%0d", i), dout_last, i == 4);
        end
        check("post_rst_empty", empty, 1'b1);

`ifdef TMEC_CORRECT_ERRCNT_EN
        // Error count saturates at T+1=4, then restarts on the next codeword.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, ea[i], 1'b1);
            check($sformatf("cnt_a_valid%0d", i), err_count_valid, i == 4);
        end
        check("cnt_a_sat", err_count, 3'd4);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, eb[i], 1'b1);
            check($sformatf("cnt_b_valid%0d", i), err_count_valid, i == 4);
        end
        check("cnt_b_total", err_count, 3'd1);
        do_reset();
        check("cnt_rst", err_count, 3'd0);
        check("cnt_rst_valid", err_count_valid, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
